// File: rtl/aes_pkg.sv
// Shared types and helpers for the iterative AES round sequencer.
// Byte k of a block is bits[8k+7:8k]; row r, column c is byte 4c+r.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    APPLY,
    DONE
  } aes_seq_state_e;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  function automatic int byte_idx(
    input int r,
    input int c
  );
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption round controller: owns the cipher state,
// fetches one round key per round and steps SubBytes/diffusion externally.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR    = NR_128,
  parameter int RK_AW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [RK_AW-1:0] rk_idx,
  input  logic [127:0]     rk_data,
  output logic [127:0]     sub_in,
  input  logic [127:0]     sub_out,
  output logic [127:0]     diff_in,
  output logic             diff_mix_en,
  input  logic [127:0]     diff_out,
  output logic             busy,
  output logic [RK_AW-1:0] round
);

  if (2 ** RK_AW <= NR) begin : g_bad_rk_aw
    $error("RK_AW too narrow to count NR rounds");
  end

  localparam logic [RK_AW-1:0] LAST = RK_AW'(NR);

  aes_seq_state_e   fsm;
  aes_block_t       state;
  logic [RK_AW-1:0] rnd;
  aes_block_t       key_src;
  aes_block_t       next_state;
  logic             last_rnd;

  assign last_rnd = (rnd == LAST);

  // Round 0 is the bare initial key addition; later rounds
  // take the diffused SubBytes result.
  always_comb begin
    key_src    = (rnd == '0) ? state : diff_out;
    next_state = key_src ^ rk_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm   <= IDLE;
      state <= '0;
      rnd   <= '0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (in_valid) begin
            state <= in_data;
            rnd   <= '0;
            fsm   <= FETCH;
          end
        end
        FETCH: begin
          fsm <= APPLY;
        end
        APPLY: begin
          state <= next_state;
          if (last_rnd) begin
            fsm <= DONE;
          end else begin
            rnd <= rnd + 1'b1;
            fsm <= FETCH;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready    = (fsm == IDLE);
  assign out_valid   = (fsm == DONE);
  assign busy        = (fsm != IDLE);
  assign out_data    = state;
  assign rk_idx      = rnd;
  assign round       = rnd;
  assign sub_in      = state;
  assign diff_in     = sub_out;
  assign diff_mix_en = !last_rnd;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer with real SubBytes, diffusion,
// a registered key store and a ciphertext scoreboard.
module tb_aes_round_sequencer;
  import aes_pkg::*;

  localparam int NR    = NR_128;
  localparam int RK_AW = 4;

  typedef struct {
    aes_block_t key;
    aes_block_t pt;
    aes_block_t ct;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic [RK_AW-1:0] rk_idx;
  logic [127:0]     rk_data;
  logic [127:0]     sub_in;
  logic [127:0]     sub_out;
  logic [127:0]     diff_in;
  logic             diff_mix_en;
  logic [127:0]     diff_out;
  logic             busy;
  logic [RK_AW-1:0] round;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         out_cyc = 0;
  aes_block_t exp_cur;
  aes_block_t sb[$];
  aes_block_t rk_mem[16];
  logic [7:0] sbox[256];
  vec_t       vecs[3];

  aes_round_sequencer #(
    .NR    (NR),
    .RK_AW (RK_AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .rk_idx      (rk_idx),
    .rk_data     (rk_data),
    .sub_in      (sub_in),
    .sub_out     (sub_out),
    .diff_in     (diff_in),
    .diff_mix_en (diff_mix_en),
    .diff_out    (diff_out),
    .busy        (busy),
    .round       (round)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rk_data <= rk_mem[rk_idx];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p = '0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] a,
    input int n
  );
    return (a << n) | (a >> (8 - n));
  endfunction

  // S-box from the GF(2^8) inverse plus the affine map.
  function automatic logic [7:0] sbox_calc(input int x);
    logic [7:0] inv = '0;
    for (int y = 1; y < 256; y++)
      if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^
           rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic aes_block_t sub_bytes(input aes_block_t s);
    aes_block_t o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox[s[8*k +: 8]];
    return o;
  endfunction

  function automatic aes_block_t diffuse(
    input aes_block_t s,
    input logic mix
  );
    aes_block_t t;
    aes_block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[8*byte_idx(r, c) +: 8] = s[8*byte_idx(r, (c + r) % 4) +: 8];
    o = t;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[8*byte_idx(0, c) +: 8];
        a1 = t[8*byte_idx(1, c) +: 8];
        a2 = t[8*byte_idx(2, c) +: 8];
        a3 = t[8*byte_idx(3, c) +: 8];
        o[8*byte_idx(0, c) +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        o[8*byte_idx(1, c) +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        o[8*byte_idx(2, c) +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        o[8*byte_idx(3, c) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    return o;
  endfunction

  // FIPS hex strings list byte 0 first; the port map puts byte 0 in bits[7:0].
  function automatic aes_block_t swap(input aes_block_t x);
    aes_block_t o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = x[8*(15 - k) +: 8];
    return o;
  endfunction

  function automatic aes_block_t encrypt(input aes_block_t pt);
    aes_block_t s = pt ^ rk_mem[0];
    for (int r = 1; r <= NR; r++)
      s = diffuse(sub_bytes(s), r != NR) ^ rk_mem[r];
    return s;
  endfunction

  always_comb sub_out = sub_bytes(sub_in);
  always_comb diff_out = diffuse(diff_in, diff_mix_en);

  task automatic load_key(input aes_block_t key_fips);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key_fips[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]],
             sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;
    for (int r = 0; r <= NR; r++)
      rk_mem[r] = swap({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  task automatic chk(
    input string      nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(
    input string nm,
    input logic  act,
    input logic  exp
  );
    chk(nm, 128'(act), 128'(exp));
  endtask

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) sb.push_back(exp_cur);
      if (out_valid && out_ready) begin
        out_cyc = cyc;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_empty: got %h want none", out_data);
        end else begin
          chk("scoreboard_ct", out_data, sb.pop_front());
        end
      end
      if (in_ready === busy) chk1("ready_vs_busy", in_ready, !busy);
    end
  end

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!(in_valid && in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got none want accept");
    end
  endtask

  task automatic wait_out();
    int n = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL out_timeout: got none want handshake");
    end
  endtask

  task automatic send(
    input aes_block_t pt,
    input aes_block_t ct,
    input bit         probe
  );
    int         first = 0;
    bit         ok_rk = 1'b1;
    bit         ok_mix = 1'b1;
    bit         ok_busy = 1'b1;
    aes_block_t hold;
    @(posedge clk);
    #1;
    exp_cur   = ct;
    in_data   = pt;
    in_valid  = 1'b1;
    out_ready = !probe;
    wait_accept();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 60 && first == 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        first = k;
      end else begin
        if (rk_idx !== 4'((k - 1) / 2)) ok_rk = 1'b0;
        if (busy !== 1'b1 || in_ready !== 1'b0) ok_busy = 1'b0;
        if (k % 2 == 0 && diff_mix_en !== ((k - 1) / 2 != NR))
          ok_mix = 1'b0;
        if (probe && k == 3)
          chk("round0_state", sub_in,
              swap(128'h193de3bea0f4e22b9ac68d2ae9f84808));
      end
    end
    if (probe) begin
      chk("latency", 128'(first), 128'(2 * (NR + 1) + 1));
      chk1("rk_idx_seq", ok_rk, 1'b1);
      chk1("mix_en_seq", ok_mix, 1'b1);
      chk1("busy_span", ok_busy, 1'b1);
      hold = out_data;
      repeat (6) begin
        @(negedge clk);
        chk1("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, hold);
        chk1("hold_in_ready", in_ready, 1'b0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk1("idle_in_ready", in_ready, 1'b1);
      chk1("idle_out_valid", out_valid, 1'b0);
      chk1("idle_busy", busy, 1'b0);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int acc1;
    int acc2;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    exp_cur   = '0;
    for (int x = 0; x < 256; x++) sbox[x] = sbox_calc(x);
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;
    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt:  128'h3243f6a8885a308d313198a2e0370734,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                pt:  128'h00112233445566778899aabbccddeeff,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{key: '0,
                pt:  '0,
                ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_rk_idx", 128'(rk_idx), 128'(0));
    chk("rst_round", 128'(round), 128'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_state", sub_in, '0);

    for (int i = 0; i < 3; i++) begin
      load_key(vecs[i].key);
      chk("model_vs_table", encrypt(swap(vecs[i].pt)), swap(vecs[i].ct));
      send(swap(vecs[i].pt), swap(vecs[i].ct), i == 0);
    end

    // Back-to-back offers: the second must wait for the first handshake.
    load_key('0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_data   = swap(vecs[0].pt);
    exp_cur   = encrypt(swap(vecs[0].pt));
    in_valid  = 1'b1;
    wait_accept();
    acc1 = cyc;
    @(posedge clk);
    #1;
    in_data = '0;
    exp_cur = swap(vecs[2].ct);
    wait_accept();
    acc2 = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_after_handshake", 128'(acc2 - out_cyc), 128'(1));
    chk("b2b_throughput", 128'(acc2 - acc1), 128'(2 * (NR + 1) + 2));
    wait_out();
    @(posedge clk);
    #1;

    // Reset during round 5 APPLY discards the block.
    load_key(vecs[0].key);
    in_data  = swap(vecs[0].pt);
    exp_cur  = swap(vecs[0].ct);
    in_valid = 1'b1;
    wait_accept();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_round", 128'(round), 128'(5));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_state", sub_in, '0);
    send(swap(vecs[0].pt), swap(vecs[0].ct), 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
